// File: rtl/pacman_sprite_renderer_if.sv
// Scan, object-state, ROM and pixel-flag bundle between the video/game side and the sprite renderer.
// master = video/game/ROM side, slave = renderer.
interface pacman_sprite_renderer_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  pac_x;
    logic [9:0]  pac_y;
    logic [1:0]  pac_dir;
    logic        pac_moving;
    logic [9:0]  ghost_x;
    logic [9:0]  ghost_y;
    logic [7:0]  open_addr;
    logic [31:0] open_data;
    logic [7:0]  closed_addr;
    logic [31:0] closed_data;
    logic [7:0]  ghost_addr;
    logic [31:0] ghost_data;
    logic        pac_on;
    logic        ghost_on;
    logic        mouth_open;

    modport master (
        output frame_clk, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving,
               ghost_x, ghost_y, open_data, closed_data, ghost_data,
        input  open_addr, closed_addr, ghost_addr, pac_on, ghost_on, mouth_open
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving,
               ghost_x, ghost_y, open_data, closed_data, ghost_data,
        output open_addr, closed_addr, ghost_addr, pac_on, ghost_on, mouth_open
    );
endinterface

// File: rtl/pacman_sprite_renderer.sv
// Per-pixel Pac-Man/ghost sprite hit + ROM bit extraction with per-frame state latch and mouth animation.
// Latency: scan -> ROM address 1 cycle, -> pac_on/ghost_on 2 cycles; no backpressure, 1 pixel/cycle.
module pacman_sprite_renderer #(
    parameter int SPRITE_SIZE = 32,
    parameter int ANIM_PERIOD = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    pacman_sprite_renderer_if.slave  bus
);
    localparam logic [10:0] SIZE11    = 11'(SPRITE_SIZE);
    localparam logic [4:0]  COL_MAX   = 5'(SPRITE_SIZE - 1);
    localparam logic [7:0]  ANIM_LAST = 8'(ANIM_PERIOD - 1);

    // frame sync
    logic frame_s1_q, frame_s1_d;
    logic frame_s2_q, frame_s2_d;
    logic frame_s3_q, frame_s3_d;
    logic frame_tick;

    // per-frame shadow state and animation
    logic [9:0] pac_x_q, pac_x_d, pac_y_q, pac_y_d;
    logic [9:0] ghost_x_q, ghost_x_d, ghost_y_q, ghost_y_d;
    logic [1:0] pac_dir_q, pac_dir_d;
    logic       pac_moving_q, pac_moving_d;
    logic [7:0] anim_cnt_q, anim_cnt_d;
    logic       mouth_open_q, mouth_open_d;

    // stage 1
    logic       hit_p_q, hit_p_d, hit_g_q, hit_g_d;
    logic [4:0] col_p_q, col_p_d, col_g_q, col_g_d;
    logic [4:0] row_p_q, row_p_d, row_g_q, row_g_d;
    logic       mouth_s1_q, mouth_s1_d;

    // stage 2
    logic       pac_on_q, pac_on_d, ghost_on_q, ghost_on_d;

    logic [10:0] draw_x11, draw_y11;
    logic [10:0] pac_x11, pac_y11, ghost_x11, ghost_y11;
    logic [31:0] pac_row;

    always_comb begin
        frame_s1_d = bus.frame_clk;
        frame_s2_d = frame_s1_q;
        frame_s3_d = frame_s2_q;
        frame_tick = frame_s2_q & ~frame_s3_q;

        pac_x_d      = pac_x_q;
        pac_y_d      = pac_y_q;
        pac_dir_d    = pac_dir_q;
        pac_moving_d = pac_moving_q;
        ghost_x_d    = ghost_x_q;
        ghost_y_d    = ghost_y_q;
        anim_cnt_d   = anim_cnt_q;
        mouth_open_d = mouth_open_q;

        if (frame_tick) begin
            pac_x_d      = bus.pac_x;
            pac_y_d      = bus.pac_y;
            pac_dir_d    = bus.pac_dir;
            pac_moving_d = bus.pac_moving;
            ghost_x_d    = bus.ghost_x;
            ghost_y_d    = bus.ghost_y;
            // Animation reacts to the motion flag being latched on this same tick.
            if (pac_moving_d) begin
                if (anim_cnt_q == ANIM_LAST) begin
                    anim_cnt_d   = 8'd0;
                    mouth_open_d = ~mouth_open_q;
                end else begin
                    anim_cnt_d   = anim_cnt_q + 8'd1;
                end
            end else begin
                anim_cnt_d   = 8'd0;
                mouth_open_d = 1'b1;
            end
        end

        // 11-bit window ends so objects near x=1023 never wrap to column 0.
        draw_x11  = {1'b0, bus.DrawX};
        draw_y11  = {1'b0, bus.DrawY};
        pac_x11   = {1'b0, pac_x_q};
        pac_y11   = {1'b0, pac_y_q};
        ghost_x11 = {1'b0, ghost_x_q};
        ghost_y11 = {1'b0, ghost_y_q};

        hit_p_d = (draw_x11 >= pac_x11) && (draw_x11 < pac_x11 + SIZE11) &&
                  (draw_y11 >= pac_y11) && (draw_y11 < pac_y11 + SIZE11);
        hit_g_d = (draw_x11 >= ghost_x11) && (draw_x11 < ghost_x11 + SIZE11) &&
                  (draw_y11 >= ghost_y11) && (draw_y11 < ghost_y11 + SIZE11);
        col_p_d    = bus.DrawX[4:0] - pac_x_q[4:0];
        row_p_d    = bus.DrawY[4:0] - pac_y_q[4:0];
        col_g_d    = bus.DrawX[4:0] - ghost_x_q[4:0];
        row_g_d    = bus.DrawY[4:0] - ghost_y_q[4:0];
        mouth_s1_d = mouth_open_q;

        // Column 0 sits in the ROM word's MSB.
        pac_row    = mouth_s1_q ? bus.open_data : bus.closed_data;
        pac_on_d   = hit_p_q & pac_row[COL_MAX - col_p_q];
        ghost_on_d = hit_g_q & bus.ghost_data[COL_MAX - col_g_q];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_s1_q   <= 1'b0;
            frame_s2_q   <= 1'b0;
            frame_s3_q   <= 1'b0;
            pac_x_q      <= 10'd0;
            pac_y_q      <= 10'd0;
            pac_dir_q    <= 2'd0;
            pac_moving_q <= 1'b0;
            ghost_x_q    <= 10'd0;
            ghost_y_q    <= 10'd0;
            anim_cnt_q   <= 8'd0;
            mouth_open_q <= 1'b1;
            hit_p_q      <= 1'b0;
            hit_g_q      <= 1'b0;
            col_p_q      <= 5'd0;
            col_g_q      <= 5'd0;
            row_p_q      <= 5'd0;
            row_g_q      <= 5'd0;
            mouth_s1_q   <= 1'b1;
            pac_on_q     <= 1'b0;
            ghost_on_q   <= 1'b0;
        end else begin
            frame_s1_q   <= frame_s1_d;
            frame_s2_q   <= frame_s2_d;
            frame_s3_q   <= frame_s3_d;
            pac_x_q      <= pac_x_d;
            pac_y_q      <= pac_y_d;
            pac_dir_q    <= pac_dir_d;
            pac_moving_q <= pac_moving_d;
            ghost_x_q    <= ghost_x_d;
            ghost_y_q    <= ghost_y_d;
            anim_cnt_q   <= anim_cnt_d;
            mouth_open_q <= mouth_open_d;
            hit_p_q      <= hit_p_d;
            hit_g_q      <= hit_g_d;
            col_p_q      <= col_p_d;
            col_g_q      <= col_g_d;
            row_p_q      <= row_p_d;
            row_g_q      <= row_g_d;
            mouth_s1_q   <= mouth_s1_d;
            pac_on_q     <= pac_on_d;
            ghost_on_q   <= ghost_on_d;
        end
    end

    assign bus.open_addr   = {1'b0, pac_dir_q, row_p_q};
    assign bus.closed_addr = {3'b000, row_p_q};
    assign bus.ghost_addr  = {3'b100, row_g_q};
    assign bus.pac_on      = pac_on_q;
    assign bus.ghost_on    = ghost_on_q;
    assign bus.mouth_open  = mouth_open_q;
endmodule

// File: doc/pacman_sprite_renderer.md
# pacman_sprite_renderer

Per-pixel sprite renderer between the VGA scan counters and the colour mapper. It takes the current scan position plus the Pac-Man and ghost positions, drives the address ports of the three 32x32 sprite ROMs (directional Pac-Man, closed-mouth Pac-Man, ghost), and extracts the pixel bit. It outputs registered `pac_on` / `ghost_on` flags two cycles after the scan position. It also owns the mouth-chomp animation and latches object state once per video frame.

## Interface
- `SPRITE_SIZE`, 32: sprite width/height in pixels; fixed, governs 5-bit row/column math.
- `ANIM_PERIOD`, 8: video frames per mouth toggle while moving; legal range 1..255.

- `Clk`  in  1: pixel clock; all state on rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state immediately.
- `frame_clk`  in  1: once-per-frame pulse/level from VGA controller (asynchronous to `Clk` is allowed).
- `DrawX`, `DrawY`  in  10 each: current scan position, advances each `Clk`.
- `pac_x`, `pac_y`  in  10 each: Pac-Man top-left corner.
- `pac_dir`  in  2: 0=right, 1=left, 2=up, 3=down.
- `pac_moving`  in  1: animate mouth when 1.
- `ghost_x`, `ghost_y`  in  10 each: ghost top-left corner.
- `open_addr`  out  8: address to directional ROM for Pac-Man.
- `open_data`  in  32: combinational ROM row data.
- `closed_addr`  out  8: address to closed-mouth ROM.
- `closed_data`  in  32: combinational ROM row data.
- `ghost_addr`  out  8: address to second directional ROM instance (ghost frame).
- `ghost_data`  in  32: combinational ROM row data.
- `pac_on`  out  1: current pixel (delayed 2) is a lit Pac-Man pixel.
- `ghost_on`  out  1: current pixel (delayed 2) is a lit ghost pixel.
- `mouth_open`  out  1: current animation phase, for debug/sound.

## Operation
- Frame sync: `frame_clk` passes through a 2-FF synchroniser, then rising-edge detect → 1-cycle `frame_tick`.
- On `frame_tick`: latch `pac_x/pac_y/pac_dir/pac_moving/ghost_x/ghost_y` into shadow registers. All rendering uses shadow values, so no mid-frame tearing.
- Animation, evaluated on `frame_tick` using the newly latched `pac_moving`:
  - If moving: `anim_cnt` increments. When it equals `ANIM_PERIOD-1`, it wraps to 0 and `mouth_open` toggles.
  - If not moving: `anim_cnt`=0 and `mouth_open`=1 (forced open).
- Stage 1 (registered):
  - `dx = DrawX - pac_x_q` and `dy = DrawY - pac_y_q`, 10-bit unsigned.
  - `hit_p = (DrawX >= pac_x_q) && (DrawX < pac_x_q+32)`, with the same test on Y. Comparisons use 11-bit sums so no wrap occurs at x≥992.
  - Ghost uses the same math.
  - Register `hit_p`, `hit_g`, `col_p = dx[4:0]`, `col_g`, `row_p = dy[4:0]`, `row_g`, `mouth_open`.
- ROM addressing (combinational from stage-1 registers):
  - `open_addr = {1'b0, pac_dir_q, row_p}`.
  - `closed_addr = {3'b000, row_p}`.
  - `ghost_addr = {3'b100, row_g}`.
- Stage 2 (registered):
  - `pac_on = hit_p & (mouth_open_s1 ? open_data : closed_data)[31-col_p]`.
  - `ghost_on = hit_g & ghost_data[31-col_g]`.
  - Column 0 is the MSB.
- No priority between objects; both flags may be 1. The colour mapper decides.

## Timing
- Reset values: `pac_on`=0, `ghost_on`=0, `mouth_open`=1, `anim_cnt`=0, shadow registers=0 (dir=right), sync FFs=0.
- Address outputs reflect reset-cleared stage-1 registers (row 0) during reset.
- Latency: `DrawX/DrawY` at cycle N → `*_addr` valid cycle N+1 → `pac_on/ghost_on` at cycle N+2. Throughput is 1 pixel/cycle.
- `frame_clk` rise → `frame_tick` 3 `Clk` edges later (2 sync FFs + edge register). Shadow registers update on that edge.
- Pixels already in the stage-1/stage-2 registers at `frame_tick` complete using their captured phase.
- Boundaries:
  - x = pos+31 is inside; x = pos+32 is outside.
  - pos=1000 yields hits only for DrawX ≥1000 up to 1023 (no wrap to 0).
- `ANIM_PERIOD`=1 toggles every frame.
- A `pac_moving` 1→0 transition is seen at the next `frame_tick`: open mouth and counter 0 from that tick.
- Reset mid-frame clears both pipeline stages; the first valid output is 2 cycles after deassertion.

## Test plan
- Reset: pulse `Reset` mid-scan → `pac_on`=`ghost_on`=0 asynchronously, `mouth_open`=1. Both outputs stay 0 for 2 cycles after release.
- Latency/addressing:
  - Stimulus: pac at (100,200), dir=1, scan (105,210) at cycle N.
  - Required: `open_addr`=0x2A at N+1. `pac_on` at N+2 equals bit 26 of the ROM row.
- Edge pixels:
  - Stimulus: ghost at (300,300), scan x=300..332 on y=310.
  - Required: `ghost_addr`=0x8A. `ghost_on` is 0 at x=332 and for x<300 regardless of ROM data; 32-pixel window only.
- Animation: `pac_moving`=1, `ANIM_PERIOD`=8, 24 `frame_clk` pulses → `mouth_open` toggles after pulses 8, 16 and 24 (1→0→1→0).
- Frame latch: change `pac_x` from 100 to 140 mid-frame → rendering stays at 100 until 3 cycles after the next `frame_clk` rise.
- Stop/closed/overlap:
  - Stimulus: drop `pac_moving` while the mouth is closed.
  - Required: `mouth_open`=1 after the next tick.
  - Stimulus: overlapping pac/ghost at the same position.
  - Required: `pac_on` and `ghost_on` are asserted together when both ROM bits are 1.
